i2c_lcd_backpack_target: RTL and testbench
==========================================

// Module: i2c_lcd_backpack_target
// PURPOSE
//  I2C target (responder) modelling the PCF8574 8-bit port expander behind the 16x2 LCD.
//  It answers the LCD writer's transactions at address 0x27: it ACKs writes, latches each
//  data byte onto an 8-bit port and returns a port byte on reads. It sits on the shared
//  scl/sda pins, either inside the bench-side FPGA image or in simulation, so the LCD
//  command/data stream can be captured and checked. It samples SCL/SDA with the system clock.
// PARAMETERS
//  TARGET_ADDR  7'h27  7-bit I2C address this block ACKs.
//  SYNC_STAGES  2      Flip-flop synchroniser depth on scl_in and sda_in (2 or more).
//  PORT_INIT    8'hFF  Reset value of port_q. The PCF8574 powers up with all pins high.
// PORTS
//  clk        in   1  System clock. Must be at least 8x the SCL rate.
//  rst_n      in   1  Asynchronous active-low reset.
//  scl_in     in   1  SCL pin level. Asynchronous to clk.
//  sda_in     in   1  SDA pin level. Asynchronous to clk.
//  sda_oe     out  1  1 = pull SDA low (open drain); 0 = release SDA.
//  port_q     out  8  Last byte written by the controller (P7..P0).
//  rx_data    out  8  Most recent received data byte.
//  rx_valid   out  1  One-clk pulse when rx_data updates.
//  rd_data    in   8  Byte returned on a read. Latched at the address-ACK cycle.
//  busy       out  1  High from START detect to STOP detect.
//  addressed  out  1  High while a transaction to TARGET_ADDR is active.
// BEHAVIOUR
//  Reset values: sda_oe=0, port_q=PORT_INIT, rx_data=0, rx_valid=0, busy=0, addressed=0,
//   state=IDLE. Reset is asynchronous, so reset mid-transfer releases SDA immediately.
//  Synchronisation: scl_s and sda_s are the synchronised pins; edges are found by comparing
//   each against its previous value.
//   - START = sda_s falls while scl_s is high.
//   - STOP  = sda_s rises while scl_s is high.
//   - Each event is decided one clk after the edge is seen on the synchronised signal.
//  Timing rules:
//   - Input bits are sampled on the scl_s rising edge.
//   - sda_oe changes only on the scl_s falling edge (or on STOP/reset), never while SCL is high.
//  States: IDLE, ADDR, ADDR_ACK, WRITE, WR_ACK, READ, RD_ACK, IGNORE.
//   - START from any state: clear the bit counter, busy=1, go to ADDR.
//     A repeated START behaves the same way.
//   - STOP from any state: go to IDLE, busy=0, addressed=0, sda_oe=0 on the next clk.
//   - ADDR: shift in 8 bits, MSB first.
//     Bits[7:1]==TARGET_ADDR gives ADDR_ACK, with addressed=1 and rd_data latched.
//     Otherwise go to IGNORE; SDA is never driven in IGNORE.
//   - ADDR_ACK: sda_oe=1 from the SCL fall after bit 8 until the SCL fall after bit 9.
//     Then go to WRITE if R/W=0, or to READ if R/W=1.
//   - WRITE: shift in 8 bits. On the 8th SCL rise: rx_data<=byte, port_q<=byte, and
//     rx_valid pulses for 1 clk. Then go to WR_ACK.
//   - WR_ACK: ACK exactly as in ADDR_ACK, then back to WRITE. There is no byte limit.
//   - READ: drive the latched byte MSB first. On each SCL fall, sda_oe = ~bit.
//     The first bit is driven at the SCL fall that ends the address ACK.
//     After bit 0, release SDA at the next SCL fall and go to RD_ACK.
//   - RD_ACK: sample SDA on the SCL rise.
//     ACK (0): re-latch rd_data and go to READ.
//     NACK (1): go to IGNORE until STOP or START.
//  Partial bytes: a byte cut short by START/STOP is discarded.
//   port_q does not change and rx_valid does not pulse.
//  Edge ordering: if an scl_s edge and an sda_s edge land in the same clk, the SCL edge
//   is processed first. A START/STOP is then checked against the updated SCL level.
//  Latency: port_q changes SYNC_STAGES+1 clks after the 8th data-bit SCL rise at the pin.
// TESTING
//  1. Write 0x4E,0x0C,STOP -> ACK on both bytes; port_q=0x0C; one rx_valid with
//     rx_data=0x0C; busy falls after STOP.
//  2. Write 0x4C,0x55 -> NACK on the address; sda_oe stays 0; port_q remains 0xFF;
//     no rx_valid pulse.
//  3. Read 0x4F with rd_data=0xA5, controller NACKs -> controller reads 0xA5; SDA is
//     released before STOP.
//  4. Read 0x4F with rd_data=0x3C, controller ACKs, then rd_data=0xC3, then NACK ->
//     controller reads 0x3C then 0xC3.
//  5. Write 0x4E,0x12, then START mid-byte after 4 bits, then 0x4E,0x34 ->
//     port_q=0x12 then 0x34; exactly 2 rx_valid pulses.
//  6. rst_n low while sda_oe=1 during an ACK -> sda_oe=0 with no clk edge;
//     port_q=0xFF; state=IDLE.

Source files
------------

// File: rtl/i2c_lcd_backpack_target.sv
// I2C target that behaves like the PCF8574 port expander behind a 16x2 LCD.
// It ACKs writes to TARGET_ADDR, latches each data byte onto port_q, and returns
// rd_data on reads. SCL/SDA are oversampled with clk through a synchroniser.
module i2c_lcd_backpack_target #(
  parameter logic [6:0] TARGET_ADDR = 7'h27,
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] PORT_INIT   = 8'hFF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] port_q,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] rd_data,
  output logic       busy,
  output logic       addressed
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WRITE, WR_ACK, READ, RD_ACK, IGNORE
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
  logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
  logic                   scl_prev_q, scl_prev_d;
  logic                   sda_prev_q, sda_prev_d;
  logic [3:0]             bit_cnt_q, bit_cnt_d;
  logic [7:0]             shift_q, shift_d;
  logic [7:0]             tx_q, tx_d;
  logic                   rw_q, rw_d;
  logic                   sda_oe_q, sda_oe_d;
  logic [7:0]             port_d;
  logic [7:0]             rx_data_q, rx_data_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   busy_q, busy_d;
  logic                   addressed_q, addressed_d;

  logic       scl_s, sda_s;
  logic       scl_rise, scl_fall;
  logic       start_det, stop_det;
  logic [7:0] in_byte;

  assign scl_s    = scl_sync_q[SYNC_STAGES-1];
  assign sda_s    = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise = scl_s & ~scl_prev_q;
  assign scl_fall = ~scl_s & scl_prev_q;
  // START/STOP use the already-updated SCL level, so an SCL edge in the same clk wins.
  assign start_det = scl_s & sda_prev_q & ~sda_s;
  assign stop_det  = scl_s & ~sda_prev_q & sda_s;
  // Byte as it will look once the bit being sampled now is shifted in.
  assign in_byte   = {shift_q[6:0], sda_s};

  // Next-state and output logic for the bus protocol.
  always_comb begin
    // NOTE: every variable gets its hold value first so no path can infer a latch.
    state_d     = state_q;
    scl_sync_d  = {scl_sync_q[SYNC_STAGES-2:0], scl_in};
    sda_sync_d  = {sda_sync_q[SYNC_STAGES-2:0], sda_in};
    scl_prev_d  = scl_s;
    sda_prev_d  = sda_s;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    tx_d        = tx_q;
    rw_d        = rw_q;
    sda_oe_d    = sda_oe_q;
    port_d      = port_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    busy_d      = busy_q;
    addressed_d = addressed_q;

    unique case (state_q)
      ADDR: begin
        if (scl_rise) begin
          shift_d   = in_byte;
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd7) begin
            bit_cnt_d = 4'd0;
            if (in_byte[7:1] == TARGET_ADDR) begin
              state_d     = ADDR_ACK;
              addressed_d = 1'b1;
              tx_d        = rd_data;
              rw_d        = in_byte[0];
            end else begin
              state_d     = IGNORE;
              addressed_d = 1'b0;
            end
          end
        end
      end
      ADDR_ACK: begin
        // First fall starts the ACK; the second fall ends it.
        if (scl_fall) begin
          if (!sda_oe_q) begin
            sda_oe_d = 1'b1;
          end else if (rw_q) begin
            state_d   = READ;
            sda_oe_d  = ~tx_q[7];
            tx_d      = {tx_q[6:0], 1'b0};
            bit_cnt_d = 4'd1;
          end else begin
            state_d   = WRITE;
            sda_oe_d  = 1'b0;
            bit_cnt_d = 4'd0;
          end
        end
      end
      WRITE: begin
        if (scl_rise) begin
          shift_d   = in_byte;
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd7) begin
            bit_cnt_d  = 4'd0;
            rx_data_d  = in_byte;
            port_d     = in_byte;
            rx_valid_d = 1'b1;
            state_d    = WR_ACK;
          end
        end
      end
      WR_ACK: begin
        if (scl_fall) begin
          if (!sda_oe_q) begin
            sda_oe_d = 1'b1;
          end else begin
            sda_oe_d = 1'b0;
            state_d  = WRITE;
          end
        end
      end
      READ: begin
        // bit_cnt counts bits already put on the bus; after 8, release for the ACK.
        if (scl_fall) begin
          if (bit_cnt_q == 4'd8) begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = 4'd0;
            state_d   = RD_ACK;
          end else begin
            sda_oe_d  = ~tx_q[7];
            tx_d      = {tx_q[6:0], 1'b0};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end
      RD_ACK: begin
        if (scl_rise) begin
          if (!sda_s) begin
            tx_d      = rd_data;
            bit_cnt_d = 4'd0;
            state_d   = READ;
          end else begin
            state_d = IGNORE;
          end
        end
      end
      default: ;
    endcase

    if (start_det) begin
      state_d   = ADDR;
      bit_cnt_d = 4'd0;
      busy_d    = 1'b1;
    end else if (stop_det) begin
      state_d     = IDLE;
      busy_d      = 1'b0;
      addressed_d = 1'b0;
      sda_oe_d    = 1'b0;
    end
  end

  // State registers; asynchronous reset releases SDA immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      scl_sync_q  <= '1;
      sda_sync_q  <= '1;
      scl_prev_q  <= 1'b1;
      sda_prev_q  <= 1'b1;
      bit_cnt_q   <= 4'd0;
      shift_q     <= 8'h00;
      tx_q        <= 8'h00;
      rw_q        <= 1'b0;
      sda_oe_q    <= 1'b0;
      port_q      <= PORT_INIT;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
      addressed_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      state_q     <= state_d;
      scl_sync_q  <= scl_sync_d;
      sda_sync_q  <= sda_sync_d;
      scl_prev_q  <= scl_prev_d;
      sda_prev_q  <= sda_prev_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      tx_q        <= tx_d;
      rw_q        <= rw_d;
      sda_oe_q    <= sda_oe_d;
      port_q      <= port_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      busy_q      <= busy_d;
      addressed_q <= addressed_d;
    end
  end

  assign sda_oe    = sda_oe_q;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign busy      = busy_q;
  assign addressed = addressed_q;

endmodule

// File: tb/tb_i2c_lcd_backpack_target.sv
// Directed bench for i2c_lcd_backpack_target: a bit-banged I2C controller on an
// open-drain bus, checking ACKs, port updates, reads and asynchronous reset.
module tb_i2c_lcd_backpack_target;

  localparam int Q = 8;  // clks per quarter SCL period

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_line;
  logic       sda_oe;
  logic [7:0] port_q;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] rd_data = 8'h00;
  logic       busy;
  logic       addressed;

  int total = 0;
  int bad = 0;
  int rx_pulses = 0;
  logic oe_seen = 1'b0;

  assign sda_line = sda_m & ~sda_oe;

  always #5 clk = ~clk;

  i2c_lcd_backpack_target dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .scl_in   (scl),
    .sda_in   (sda_line),
    .sda_oe   (sda_oe),
    .port_q   (port_q),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rd_data  (rd_data),
    .busy     (busy),
    .addressed(addressed)
  );

  // Pulse counter and SDA-drive watcher, sampled away from the active edge.
  always @(negedge clk) begin
    if (rx_valid) rx_pulses++;
    if (sda_oe) oe_seen = 1'b1;
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_q();
    repeat (Q) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; wait_q();
    scl = 1'b1;   wait_q();
    sda_m = 1'b0; wait_q();
    scl = 1'b0;   wait_q();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wait_q();
    scl = 1'b1;   wait_q();
    sda_m = 1'b1; wait_q();
  endtask

  task automatic write_bit(input logic b);
    sda_m = b; wait_q();
    scl = 1'b1; wait_q(); wait_q();
    scl = 1'b0; wait_q();
  endtask

  task automatic read_bit(output logic b);
    sda_m = 1'b1; wait_q();
    scl = 1'b1;   wait_q();
    b = sda_line; wait_q();
    scl = 1'b0;   wait_q();
  endtask

  task automatic write_byte(input logic [7:0] data, output logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) write_bit(data[i]);
    read_bit(b);
    ack = ~b;
  endtask

  task automatic read_byte(output logic [7:0] data, input logic give_ack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      data[i] = b;
    end
    write_bit(~give_ack);
  endtask

  initial begin
    logic       ack;
    logic [7:0] rb;
    int         p0;
    logic [7:0] a4e;

    // Reset values
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_q();
    check("rst_sda_oe", {7'd0, sda_oe}, 8'h00);
    check("rst_port_q", port_q, 8'hFF);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_rx_valid", {7'd0, rx_valid}, 8'h00);
    check("rst_busy", {7'd0, busy}, 8'h00);
    check("rst_addressed", {7'd0, addressed}, 8'h00);

    // Wrong address: never driven, nothing latched
    oe_seen = 1'b0;
    p0 = rx_pulses;
    i2c_start();
    check("t2_busy", {7'd0, busy}, 8'h01);
    write_byte(8'h4C, ack);
    check("t2_addr_nack", {7'd0, ack}, 8'h00);
    write_byte(8'h55, ack);
    check("t2_data_nack", {7'd0, ack}, 8'h00);
    i2c_stop();
    check("t2_oe_never", {7'd0, oe_seen}, 8'h00);
    check("t2_port_q", port_q, 8'hFF);
    check("t2_pulses", 8'(rx_pulses - p0), 8'h00);

    // Write 0x0C to the backpack
    p0 = rx_pulses;
    i2c_start();
    write_byte(8'h4E, ack);
    check("t1_addr_ack", {7'd0, ack}, 8'h01);
    check("t1_addressed", {7'd0, addressed}, 8'h01);
    write_byte(8'h0C, ack);
    check("t1_data_ack", {7'd0, ack}, 8'h01);
    check("t1_port_q", port_q, 8'h0C);
    check("t1_rx_data", rx_data, 8'h0C);
    check("t1_pulses", 8'(rx_pulses - p0), 8'h01);
    check("t1_busy_before_stop", {7'd0, busy}, 8'h01);
    i2c_stop();
    check("t1_busy_after_stop", {7'd0, busy}, 8'h00);
    check("t1_addressed_after_stop", {7'd0, addressed}, 8'h00);

    // Single-byte read, controller NACKs; rd_data changed after latch must not matter
    rd_data = 8'hA5;
    i2c_start();
    write_byte(8'h4F, ack);
    check("t3_addr_ack", {7'd0, ack}, 8'h01);
    rd_data = 8'h00;
    read_byte(rb, 1'b0);
    check("t3_read", rb, 8'hA5);
    check("t3_released", {7'd0, sda_oe}, 8'h00);
    i2c_stop();
    check("t3_busy_after_stop", {7'd0, busy}, 8'h00);

    // Two-byte read: ACK re-latches rd_data
    rd_data = 8'h3C;
    i2c_start();
    write_byte(8'h4F, ack);
    check("t4_addr_ack", {7'd0, ack}, 8'h01);
    rd_data = 8'hC3;
    read_byte(rb, 1'b1);
    check("t4_read0", rb, 8'h3C);
    read_byte(rb, 1'b0);
    check("t4_read1", rb, 8'hC3);
    i2c_stop();

    // Repeated START cuts a byte short; partial byte is dropped
    p0 = rx_pulses;
    a4e = 8'h4E;
    i2c_start();
    write_byte(8'h4E, ack);
    write_byte(8'h12, ack);
    check("t5_first_ack", {7'd0, ack}, 8'h01);
    check("t5_port_first", port_q, 8'h12);
    for (int i = 7; i >= 4; i--) write_bit(a4e[i]);
    i2c_start();
    check("t5_port_after_partial", port_q, 8'h12);
    write_byte(8'h4E, ack);
    check("t5_readdr_ack", {7'd0, ack}, 8'h01);
    write_byte(8'h34, ack);
    i2c_stop();
    check("t5_port_second", port_q, 8'h34);
    check("t5_rx_data", rx_data, 8'h34);
    check("t5_pulses", 8'(rx_pulses - p0), 8'h02);

    // Asynchronous reset while the address ACK is being driven
    i2c_start();
    for (int i = 7; i >= 0; i--) write_bit(a4e[i]);
    check("t6_oe_in_ack", {7'd0, sda_oe}, 8'h01);
    check("t6_addressed", {7'd0, addressed}, 8'h01);
    #1 rst_n = 1'b0;
    #1;
    check("t6_oe_async", {7'd0, sda_oe}, 8'h00);
    check("t6_port_q", port_q, 8'hFF);
    check("t6_busy", {7'd0, busy}, 8'h00);
    check("t6_addressed_clr", {7'd0, addressed}, 8'h00);
    wait_q();
    rst_n = 1'b1;
    i2c_stop();
    check("t6_idle_after", {7'd0, busy}, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
